// File: rtl/aes_spi_frame_slave.sv
// aes_spi_frame_slave
// SPI slave front-end for an external AES cipher core. A frame carries a
// command byte, a 128-bit block and an optional key. The frame then starts the
// cipher, waits for its result and streams 128 result bits back on SDO.
// Optional feature macro: AES_SPI_STATUS_EN. When it is defined, an 8-bit
// status byte {1, err, decrypt, key_valid, 0000} is sent ahead of the result.
module aes_spi_frame_slave #(
    parameter int NK      = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             CS,
    input  logic             SDI,
    output logic             SDO,
    output logic [127:0]     aes_data,
    output logic [32*NK-1:0] aes_key,
    output logic             aes_decrypt,
    output logic             aes_start,
    input  logic             aes_done,
    input  logic [127:0]     aes_result,
    output logic             frame_done,
    output logic             err
);
    localparam int KW = 32 * NK;
    localparam int CW = $clog2(KW + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_DATA, S_KEY, S_START, S_WAIT, S_STAT, S_SHIFT
    } state_t;

    // State that follows a finished (or failed) cipher run.
`ifdef AES_SPI_STATUS_EN
    localparam state_t RES_ST = S_STAT;
`else
    localparam state_t RES_ST = S_SHIFT;
`endif

    state_t        state, next_state;
    logic [CW-1:0] bcnt;
    logic [TW-1:0] wcnt;
    logic [6:0]    cmd_sr;
    logic          load_key;
    logic          key_valid;
    logic          armed;
    logic [KW-2:0] key_sh;
    logic [127:0]  out_sr;
    logic [127:0]  res_cap;
    logic          frame_go, cmd_last, data_last, key_last, shift_last, wait_to;
    logic          captured, enter_res, err_set;
    logic          sdo_nxt, start_nxt, fd_nxt;
`ifdef AES_SPI_STATUS_EN
    logic [6:0]    stat_sr;
    logic          stat_last;

    assign stat_last = (bcnt == CW'(7));
`endif

    // A frame starts only once CS has been seen high since the previous one.
    assign frame_go   = !CS && (state == S_IDLE) && armed;
    // The first command bit is taken in IDLE, so CMD holds for 7 more bits.
    assign cmd_last   = (bcnt == CW'(6));
    assign data_last  = (bcnt == CW'(127));
    assign key_last   = (bcnt == CW'(KW - 1));
    assign shift_last = (bcnt == CW'(127));
    assign wait_to    = (wcnt == TW'(TIMEOUT - 1));
    assign captured   = (state == S_WAIT) && aes_done;
    // A failed run (no key or timeout) reports an all-zero result.
    assign res_cap    = captured ? aes_result : '0;
    assign enter_res  = !CS && (((state == S_START) && !key_valid) ||
                                ((state == S_WAIT) && (aes_done || wait_to)));
    assign err_set    = enter_res && !captured;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next-state logic; CS high aborts from every state
    always_comb begin
        next_state = state;
        if (CS) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (armed) next_state = S_CMD;
                S_CMD:   if (cmd_last) next_state = S_DATA;
                S_DATA:  if (data_last) next_state = load_key ? S_KEY : S_START;
                S_KEY:   if (key_last) next_state = S_START;
                S_START: next_state = key_valid ? S_WAIT : RES_ST;
                S_WAIT:  if (aes_done || wait_to) next_state = RES_ST;
`ifdef AES_SPI_STATUS_EN
                S_STAT:  if (stat_last) next_state = S_SHIFT;
`endif
                S_SHIFT: if (shift_last) next_state = S_IDLE;
                default: next_state = S_IDLE;
            endcase
        end
    end

    // Output logic: next values of the registered SDO / aes_start / frame_done
    always_comb begin
        sdo_nxt   = 1'b0;
        start_nxt = 1'b0;
        fd_nxt    = 1'b0;
        if (!CS) begin
            if (enter_res) begin
`ifdef AES_SPI_STATUS_EN
                sdo_nxt = 1'b1;
`else
                sdo_nxt = res_cap[127];
`endif
            end else if (state == S_SHIFT) begin
                sdo_nxt = shift_last ? 1'b0 : out_sr[127];
            end
`ifdef AES_SPI_STATUS_EN
            else if (state == S_STAT) begin
                sdo_nxt = stat_last ? out_sr[127] : stat_sr[6];
            end
`endif
            // A key committed on the last KEY bit already counts for START.
            start_nxt = (next_state == S_START) && (key_valid || (state == S_KEY));
            fd_nxt    = (state == S_SHIFT) && shift_last;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            SDO        <= 1'b0;
            aes_start  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            SDO        <= sdo_nxt;
            aes_start  <= start_nxt;
            frame_done <= fd_nxt;
        end
    end

    // Bit counter clears on each state change; wait counter runs only in WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt <= '0;
            wcnt <= '0;
        end else begin
            if ((state == S_IDLE) || (next_state != state)) bcnt <= '0;
            else                                            bcnt <= bcnt + CW'(1);
            if ((state == S_WAIT) && (next_state == S_WAIT)) wcnt <= wcnt + TW'(1);
            else                                              wcnt <= '0;
        end
    end

    // Frame datapath: command, block, key shadow, error flag and result shifter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed       <= 1'b1;
            err         <= 1'b0;
            cmd_sr      <= '0;
            load_key    <= 1'b0;
            aes_decrypt <= 1'b0;
            aes_data    <= '0;
            key_sh      <= '0;
            aes_key     <= '0;
            key_valid   <= 1'b0;
            out_sr      <= '0;
        end else begin
            if (CS)            armed <= 1'b1;
            else if (frame_go) armed <= 1'b0;

            if (frame_go)     err <= 1'b0;
            else if (err_set) err <= 1'b1;

            if (frame_go || (!CS && (state == S_CMD)))
                cmd_sr <= {cmd_sr[5:0], SDI};
            if (!CS && (state == S_CMD) && cmd_last) begin
                load_key    <= cmd_sr[6];
                aes_decrypt <= cmd_sr[5];
            end

            if (!CS && (state == S_DATA))
                aes_data <= {aes_data[126:0], SDI};

            // The shadow only reaches aes_key on the final bit, so an abort
            // mid-key leaves the committed key and key_valid untouched.
            if (!CS && (state == S_KEY)) begin
                key_sh <= {key_sh[KW-3:0], SDI};
                if (key_last) begin
                    aes_key   <= {key_sh, SDI};
                    key_valid <= 1'b1;
                end
            end

`ifdef AES_SPI_STATUS_EN
            if (enter_res)
                out_sr <= res_cap;
            else if (!CS && ((state == S_SHIFT) || ((state == S_STAT) && stat_last)))
                out_sr <= {out_sr[126:0], 1'b0};
`else
            if (enter_res)
                out_sr <= {res_cap[126:0], 1'b0};
            else if (!CS && (state == S_SHIFT))
                out_sr <= {out_sr[126:0], 1'b0};
`endif
        end
    end

`ifdef AES_SPI_STATUS_EN
    // Status byte tail; the leading 1 goes straight to SDO on entry to STAT
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stat_sr <= '0;
        else if (enter_res)
            stat_sr <= {err | err_set, aes_decrypt, key_valid, 4'b0000};
        else if (!CS && (state == S_STAT))
            stat_sr <= {stat_sr[5:0], 1'b0};
    end
`endif

endmodule

// File: tb/tb_aes_spi_frame_slave.sv
// Scoreboarded bench for aes_spi_frame_slave: a stimulus process sends frames
// and queues the expected result stream; a monitor compares the streamed bits
// when frame_done pulses. An external cipher model answers aes_start.
`timescale 1ns/1ps
module tb_aes_spi_frame_slave;
    localparam int NK = 4;
    localparam int KW = 32 * NK;
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;

    logic          clk = 1'b0;
    logic          rst, CS, SDI, SDO;
    logic [127:0]  aes_data, aes_result;
    logic [KW-1:0] aes_key;
    logic          aes_decrypt, aes_start, aes_done, frame_done, err;

    aes_spi_frame_slave #(.NK(NK), .TIMEOUT(1023)) dut (
        .clk(clk), .rst(rst), .CS(CS), .SDI(SDI), .SDO(SDO),
        .aes_data(aes_data), .aes_key(aes_key), .aes_decrypt(aes_decrypt),
        .aes_start(aes_start), .aes_done(aes_done), .aes_result(aes_result),
        .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] res;
        logic         err;
        logic [7:0]   stat;
    } exp_t;

    exp_t          sbq[$];
    int            n_tests = 0, n_fail = 0, n_done = 0, n_starts = 0;
    logic [135:0]  hist = '0;
    logic          resp_en;
    int            resp_delay;
    logic [KW-1:0] m_key;
    logic          m_kv;

    // Stand-in cipher: real AES vectors for the known pair, a keyed mix otherwise.
    function automatic logic [127:0] cipher(input logic [127:0] d, input logic [KW-1:0] k,
                                            input logic dec);
        if (!dec && d == PT && k == KW'(K0)) return CT;
        if (dec && d == CT && k == KW'(K0)) return PT;
        return {d[63:0], d[127:64]} ^ k[127:0] ^ {128{dec}};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [KW-1:0] rndkey();
        logic [KW-1:0] k;
        for (int i = 0; i < NK; i++) k[i*32 +: 32] = $urandom();
        return k;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: on frame_done compare the last streamed bits with the queue head
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                if (sbq.size() == 0) begin
                    check("unexpected_frame_done", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("result_stream", 256'(hist[127:0]), 256'(e.res));
                    check("err_flag", 256'(err), 256'(e.err));
`ifdef AES_SPI_STATUS_EN
                    check("status_byte", 256'(hist[135:128]), 256'(e.stat));
`endif
                end
                n_done++;
            end
            hist = {hist[134:0], SDO};
        end
    end

    // Cipher model: answers each aes_start after resp_delay cycles when enabled
    initial begin : cipher_model
        int           pend;
        logic [127:0] pres;
        pend = 0;
        pres = '0;
        aes_done = 1'b0;
        aes_result = '0;
        forever begin
            @(negedge clk);
            aes_done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    aes_done = 1'b1;
                    aes_result = pres;
                end
            end else if (aes_start === 1'b1) begin
                n_starts++;
                if (resp_en) begin
                    pend = resp_delay;
                    pres = cipher(aes_data, aes_key, aes_decrypt);
                end
            end
        end
    end

    task automatic send(input logic [255:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            SDI = v[i];
            @(negedge clk);
        end
    endtask

    // One complete frame; the expected outcome comes from the frame rules alone
    task automatic run_frame(input logic [7:0] cmd, input logic [127:0] data,
                             input logic [KW-1:0] key, input int delay, input logic resp);
        exp_t e;
        int   st0, target, k;
        logic exp_start;
        if (cmd[7]) begin
            m_key = key;
            m_kv  = 1'b1;
        end
        exp_start = m_kv;
        if (!m_kv || !resp) begin
            e.res = '0;
            e.err = 1'b1;
        end else begin
            e.res = cipher(data, m_key, cmd[6]);
            e.err = 1'b0;
        end
        e.stat = {1'b1, e.err, cmd[6], m_kv, 4'b0000};
        sbq.push_back(e);
        resp_en = resp;
        resp_delay = delay;
        st0 = n_starts;
        target = n_done + 1;
        CS = 1'b0;
        send(256'(cmd), 8);
        send(256'(data), 128);
        if (cmd[7]) send(256'(key), KW);
        SDI = 1'b0;
        k = 0;
        while (n_done < target && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("frame_completes", 256'(n_done >= target), 1);
        check("start_pulses", 256'(n_starts - st0), 256'(exp_start));
        check("aes_key", 256'(aes_key), 256'(m_key));
        CS = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] cmd;
        logic       bad;
        int         d0, k;
        rst = 1'b1; CS = 1'b1; SDI = 1'b0;
        resp_en = 1'b1; resp_delay = 12;
        m_key = '0; m_kv = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_SDO", 256'(SDO), 0);
        check("rst_aes_start", 256'(aes_start), 0);
        check("rst_frame_done", 256'(frame_done), 0);
        check("rst_err", 256'(err), 0);
        check("rst_aes_data", 256'(aes_data), 0);
        check("rst_aes_key", 256'(aes_key), 0);
        check("rst_aes_decrypt", 256'(aes_decrypt), 0);
        rst = 1'b0;
        @(negedge clk);

        // No key since reset
        run_frame(8'h00, rnd128(), '0, 12, 1'b1);
        // Encrypt with key load (known vector)
        run_frame(8'h80, PT, KW'(K0), 12, 1'b1);
        // Decrypt reusing the retained key
        run_frame(8'h40, CT, '0, 12, 1'b1);
        check("decrypt_flag", 256'(aes_decrypt), 1);

        // Abort after 50 key bits: committed key must survive
        CS = 1'b0;
        send(256'(8'h80), 8);
        send(256'(rnd128()), 128);
        send(256'(rndkey()), 50);
        CS = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_key_keeps_key", 256'(aes_key), 256'(m_key));
        run_frame(8'h00, rnd128(), '0, 7, 1'b1);

        // Abort in WAIT; the late aes_done must be ignored
        resp_en = 1'b1; resp_delay = 20;
        CS = 1'b0;
        send(256'(8'h00), 8);
        send(256'(rnd128()), 128);
        SDI = 1'b0;
        repeat (4) @(negedge clk);
        CS = 1'b1;
        d0 = n_done;
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (SDO !== 1'b0 || frame_done !== 1'b0) bad = 1'b1;
        end
        check("abort_wait_quiet", 256'(bad), 0);
        check("abort_wait_no_frame", 256'(n_done), 256'(d0));

        // Timeout: cipher never answers
        run_frame(8'h00, rnd128(), '0, 0, 1'b0);

        // Randomized frames
        for (int i = 0; i < 6; i++) begin
            cmd = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom())};
            run_frame(cmd, rnd128(), rndkey(), int'($urandom_range(1, 20)), 1'b1);
        end

        // Reset during the result shift-out
        resp_en = 1'b1; resp_delay = 3;
        CS = 1'b0;
        send(256'(8'h00), 8);
        send(256'(rnd128()), 128);
        SDI = 1'b0;
        d0 = n_done;
        k = 0;
        repeat (8) @(negedge clk);
        while (SDO !== 1'b1 && k < 150) begin
            @(negedge clk);
            k++;
        end
        check("sdo_high_before_rst", 256'(SDO), 1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_SDO", 256'(SDO), 0);
        check("rst_mid_aes_key", 256'(aes_key), 0);
        check("rst_mid_aes_data", 256'(aes_data), 0);
        @(negedge clk);
        rst = 1'b0;
        CS = 1'b1;
        m_key = '0;
        m_kv = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mid_no_frame", 256'(n_done), 256'(d0));

        // key_valid was cleared by reset
        run_frame(8'h00, rnd128(), '0, 5, 1'b1);
        check("scoreboard_drained", 256'(sbq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
